// File: rtl/cr_kme_fifo_unpacker.sv
// Pops 65-bit {eof, data} entries from the KME staging FIFO and serialises each
// into two 32-bit beats, reporting per-frame word counts and overlong frames.
module cr_kme_fifo_unpacker #(
  parameter int MAX_WORDS = 512,
  parameter bit LSW_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [64:0] fifo_out,
  input  logic        fifo_out_valid,
  output logic        fifo_out_ack,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [15:0] frame_words,
  output logic        err_overlong
);

  // Handshake: a beat transfers in any cycle where out_valid and out_ready are
  // both high; a FIFO entry is consumed in any cycle where fifo_out_ack is high.
  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;

  state_t      state, state_nxt;
  logic [64:0] hold_q;
  logic [15:0] count, count_inc, count_nxt;
  logic        ovl_flag, ovl_fire, pop, frame_end;
  logic [31:0] first_half, second_half;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      EMPTY: begin
        pop = fifo_out_valid;
        if (pop) state_nxt = FIRST;
      end
      FIRST: begin
        if (out_ready) state_nxt = SECOND;
      end
      SECOND: begin
        if (out_ready) begin
          pop       = fifo_out_valid;
          state_nxt = pop ? FIRST : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // No pop may be issued while reset is held, even though state reads EMPTY.
  assign fifo_out_ack = pop & rst_n;

  assign frame_end = (state == SECOND) && out_ready && hold_q[64];
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

  always_comb begin
    count_nxt = count;
    if (frame_end) count_nxt = pop ? 16'd1 : 16'd0;
    else if (pop)  count_nxt = count_inc;
  end

  // A frame-end in the same cycle clears the flag, so the new frame may fire.
  assign ovl_fire = pop && ({1'b0, count_nxt} == 17'(MAX_WORDS + 1)) &&
                    (!ovl_flag || frame_end);

  assign first_half  = LSW_FIRST ? hold_q[31:0]  : hold_q[63:32];
  assign second_half = LSW_FIRST ? hold_q[63:32] : hold_q[31:0];

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      FIRST: begin
        out_valid = 1'b1;
        out_data  = first_half;
      end
      SECOND: begin
        out_valid = 1'b1;
        out_data  = second_half;
        out_last  = hold_q[64];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      hold_q       <= '0;
      count        <= '0;
      ovl_flag     <= 1'b0;
      frame_words  <= '0;
      frame_done   <= 1'b0;
      err_overlong <= 1'b0;
    end else begin
      state        <= state_nxt;
      if (pop) hold_q <= fifo_out;
      count        <= count_nxt;
      ovl_flag     <= frame_end ? ovl_fire : (ovl_flag | ovl_fire);
      frame_done   <= frame_end;
      if (frame_end) frame_words <= count;
      err_overlong <= ovl_fire;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_unpacker.sv
// Directed bench for cr_kme_fifo_unpacker: a FIFO model feeds two instances
// (MSW-first and LSW-first) and a scoreboard checks beats, acks and frame reports.
module tb_cr_kme_fifo_unpacker;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [64:0] fifo_out;
  logic        fifo_out_valid;
  logic        out_ready;

  logic        ack_a, valid_a, last_a, fd_a, err_a;
  logic [31:0] data_a;
  logic [15:0] fw_a;
  logic        ack_b, valid_b, last_b, fd_b, err_b;
  logic [31:0] data_b;
  logic [15:0] fw_b;

  always #5 clk = ~clk;

  cr_kme_fifo_unpacker #(.MAX_WORDS(MAXW), .LSW_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_out_ack(ack_a), .out_data(data_a), .out_valid(valid_a), .out_last(last_a),
    .out_ready(out_ready), .frame_done(fd_a), .frame_words(fw_a), .err_overlong(err_a));

  cr_kme_fifo_unpacker #(.MAX_WORDS(MAXW), .LSW_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_out_ack(ack_b), .out_data(data_b), .out_valid(valid_b), .out_last(last_b),
    .out_ready(out_ready), .frame_done(fd_b), .frame_words(fw_b), .err_overlong(err_b));

  int vectors = 0;
  int fails   = 0;

  logic [64:0] src_q[$];
  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  logic [15:0] exp_fw_q[$];

  // Reference model of the unpacker as seen from its ports
  int          st;
  logic        hold_eof, flag, exp_fd, exp_err;
  logic [15:0] fr_cnt, fw_exp;
  int          n_ack, n_err, n_valid;

  function automatic void chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endfunction

  function automatic void fail_now(string tag);
    vectors++;
    fails++;
    $error("FAIL %s: got event expected none", tag);
  endfunction

  task automatic push_word(input logic eof, input logic [63:0] d);
    src_q.push_back({eof, d});
    exp_qa.push_back({1'b0, d[63:32]});
    exp_qa.push_back({eof, d[31:0]});
    exp_qb.push_back({1'b0, d[31:0]});
    exp_qb.push_back({eof, d[63:32]});
  endtask

  task automatic model_reset();
    src_q.delete(); exp_qa.delete(); exp_qb.delete(); exp_fw_q.delete();
    st = 0; hold_eof = 1'b0; flag = 1'b0; fr_cnt = '0;
    exp_fd = 1'b0; exp_err = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ack_a"}, ack_a, 0);     chk({tag, "_ack_b"}, ack_b, 0);
    chk({tag, "_valid_a"}, valid_a, 0); chk({tag, "_valid_b"}, valid_b, 0);
    chk({tag, "_data_a"}, data_a, 0);   chk({tag, "_data_b"}, data_b, 0);
    chk({tag, "_last_a"}, last_a, 0);   chk({tag, "_last_b"}, last_b, 0);
    chk({tag, "_fd_a"}, fd_a, 0);       chk({tag, "_fw_a"}, fw_a, 0);
    chk({tag, "_err_a"}, err_a, 0);     chk({tag, "_fw_b"}, fw_b, 0);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic rdy);
    logic        exp_ack, fd_n, err_n;
    logic [64:0] e;
    logic [32:0] b;
    out_ready      = rdy;
    fifo_out_valid = (src_q.size() > 0);
    fifo_out       = fifo_out_valid ? src_q[0] : '0;
    #1;
    exp_ack = fifo_out_valid && (st == 0 || (st == 2 && out_ready));
    chk("out_valid_a", valid_a, st != 0);
    chk("out_valid_b", valid_b, st != 0);
    chk("ack_a", ack_a, exp_ack);
    chk("ack_b", ack_b, exp_ack);
    chk("frame_done_a", fd_a, exp_fd);
    chk("frame_done_b", fd_b, exp_fd);
    chk("err_overlong_a", err_a, exp_err);
    if (exp_fd) begin
      fw_exp = (exp_fw_q.size() > 0) ? exp_fw_q.pop_front() : 16'hDEAD;
      chk("frame_words_a", fw_a, fw_exp);
      chk("frame_words_b", fw_b, fw_exp);
    end
    n_ack   += int'(ack_a);
    n_err   += int'(err_a);
    n_valid += int'(valid_a);
    if (valid_a && out_ready) begin
      if (exp_qa.size() == 0) fail_now("beat_a_unexpected");
      else begin b = exp_qa.pop_front(); chk("beat_a", {last_a, data_a}, b); end
    end
    if (valid_b && out_ready) begin
      if (exp_qb.size() == 0) fail_now("beat_b_unexpected");
      else begin b = exp_qb.pop_front(); chk("beat_b", {last_b, data_b}, b); end
    end
    fd_n  = (st == 2) && out_ready && hold_eof;
    err_n = 1'b0;
    if (exp_ack) begin
      e        = src_q.pop_front();
      hold_eof = e[64];
      if (fr_cnt != 16'hFFFF) fr_cnt = fr_cnt + 16'd1;
      if (fr_cnt == 16'(MAXW + 1) && !flag) begin err_n = 1'b1; flag = 1'b1; end
      if (e[64]) begin exp_fw_q.push_back(fr_cnt); fr_cnt = '0; flag = 1'b0; end
    end
    case (st)
      0:       st = exp_ack ? 1 : 0;
      1:       st = out_ready ? 2 : 1;
      default: st = out_ready ? (exp_ack ? 1 : 0) : 2;
    endcase
    @(posedge clk);
    exp_fd  = fd_n;
    exp_err = err_n;
    @(negedge clk);
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating
  task automatic drain(input string tag, input int mode);
    logic [3:0] pat;
    bit         done;
    pat  = 4'b1001;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      done = (src_q.size() == 0) && (st == 0) && !exp_fd && !exp_err && (exp_qa.size() == 0);
      if (done) break;
      cycle(mode == 0 ? 1'b1 : pat[k % 4]);
    end
    if (!done) fail_now({tag, "_timeout"});
  endtask

  initial begin
    int base_ack, base_err, base_valid;
    model_reset();
    n_ack = 0; n_err = 0; n_valid = 0;
    rst_n = 1'b0; fifo_out = '0; fifo_out_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-word frame
    base_ack = n_ack;
    push_word(1'b1, 64'h1111_2222_3333_4444);
    drain("single", 0);
    chk("single_acks", n_ack - base_ack, 1);

    // 8-word back-to-back frame
    base_ack = n_ack; base_valid = n_valid;
    for (int i = 0; i < 8; i++) push_word(i == 7, {$urandom(), $urandom()});
    drain("burst", 0);
    chk("burst_acks", n_ack - base_ack, 8);
    chk("burst_valid_cycles", n_valid - base_valid, 16);

    // Backpressure on a 3-word frame
    for (int i = 0; i < 3; i++) push_word(i == 2, {$urandom(), $urandom()});
    drain("bp", 1);

    // Overlong: 6 words with MAX_WORDS=4, then a clean 2-word frame
    base_err = n_err;
    for (int i = 0; i < 6; i++) push_word(i == 5, {32'hC0DE_0000 | i, $urandom()});
    drain("ovl", 0);
    chk("ovl_err_pulses", n_err - base_err, 1);
    base_err = n_err;
    for (int i = 0; i < 2; i++) push_word(i == 1, {$urandom(), $urandom()});
    drain("post_ovl", 0);
    chk("post_ovl_err_pulses", n_err - base_err, 0);

    // Both orders on a known word
    push_word(1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    drain("lsw", 0);

    // Random-length frames with random backpressure
    for (int f = 0; f < 4; f++) begin
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) push_word(i == len - 1, {$urandom(), $urandom()});
      for (int k = 0; k < 200 && !(src_q.size() == 0 && st == 0 && !exp_fd); k++)
        cycle(1'($urandom_range(0, 1)));
      drain("rand", 0);
    end

    // Reset in FIRST of the 3rd word of a 5-word frame
    for (int i = 0; i < 5; i++) push_word(i == 4, {$urandom(), $urandom()});
    for (int k = 0; k < 50 && !(st == 1 && fr_cnt == 16'd3); k++) cycle(1'b1);
    if (!(st == 1 && fr_cnt == 16'd3)) fail_now("reset_reach_timeout");
    rst_n = 1'b0;
    fifo_out_valid = 1'b1;
    #1 chk_zero("mid_reset");
    model_reset();
    fifo_out_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) push_word(i == 1, {$urandom(), $urandom()});
    drain("after_reset", 0);
    for (int k = 0; k < 3; k++) cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
